// File: rtl/pin_period_meter_pkg.sv
// Shared types and constants for the pin period meter and its input synchronizer.
// Pure definitions; no logic, no latency, no flow control.
package pin_period_meter_pkg;

  localparam int DEF_WIDTH = 24;
  localparam logic [DEF_WIDTH-1:0] CNT_MAX = {DEF_WIDTH{1'b1}};

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/pin_period_meter_sync_edge.sv
// Brings an asynchronous pin into CLK and emits a registered one-cycle pulse per rising edge.
// Latency: SYNC_STAGES+1 cycles from pin sample to RISE; no backpressure (free-running).
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic I,
  output logic O,
  output logic RISE
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I};
      prev_q <= sync_q[SYNC_STAGES-1];
      // Falling edges are ignored; only a 0->1 on the synced level pulses.
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign O    = sync_q[SYNC_STAGES-1];
  assign RISE = rise_q;

endmodule

// File: rtl/pin_period_meter.sv
// Measures CLK cycles between rising edges of PIN; latency SYNC_STAGES+2 from pin edge to VALID.
// Result is held until READY; a capture arriving while held is discarded and flagged in DROPPED.
module pin_period_meter
  import pin_period_meter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             PIN,
  output logic [WIDTH-1:0] O,
  output logic             VALID,
  input  logic             READY,
  output logic             OVF,
  output logic             DROPPED
);

  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   cnt_inc;
  logic             capture;
  logic             sat;
  logic             rise;
  logic             pin_lvl_unused;

  pin_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK   (CLK),
    .RESETN(RESETN),
    .I     (PIN),
    .O     (pin_lvl_unused),
    .RISE  (rise)
  );

  // Carry-out of the widened increment pins the count at all-ones.
  assign cnt_inc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
  assign sat     = (cnt_q == MAX_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_inc[WIDTH] ? MAX_CNT : cnt_inc[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      O       <= '0;
      VALID   <= 1'b0;
      OVF     <= 1'b0;
      DROPPED <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        // An accept in the same cycle frees the register for the new result.
        if (!VALID || READY) begin
          O     <= cnt_q;
          OVF   <= sat;
          VALID <= 1'b1;
        end else begin
          DROPPED <= 1'b1;
        end
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pin_period_meter.sv
// Directed bench for pin_period_meter: a 24-bit and an 8-bit instance share one stimulus,
// checked every cycle against an edge-timestamp model plus hand-computed literals.
module tb_pin_period_meter;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        pin    = 1'b0;
  logic        ready  = 1'b0;
  logic [23:0] o24;
  logic        v24, ovf24, drop24;
  logic [7:0]  o8;
  logic        v8, ovf8, drop8;

  pin_period_meter #(.WIDTH(24), .SYNC_STAGES(SYNC)) dut24 (
    .CLK(clk), .RESETN(resetn), .PIN(pin), .O(o24), .VALID(v24),
    .READY(ready), .OVF(ovf24), .DROPPED(drop24)
  );

  pin_period_meter #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
    .CLK(clk), .RESETN(resetn), .PIN(pin), .O(o8), .VALID(v8),
    .READY(ready), .OVF(ovf8), .DROPPED(drop8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  bit rise_at [0:4095];

  // Model state: index 0 is the 24-bit instance, index 1 the 8-bit one.
  int m_o   [2] = '{0, 0};
  bit m_v   [2] = '{0, 0};
  bit m_ovf [2] = '{0, 0};
  bit m_drop[2] = '{0, 0};
  int m_max [2] = '{32'hFF_FFFF, 255};
  bit have_prev = 1'b0;
  int prev_c    = 0;
  int last_rst  = 0;

  int q24[$];
  int q8[$];
  int qovf8[$];
  int first_valid = -1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // A pin edge driven after edge c is a result at edge c+LAT, worth the gap to the previous edge.
  always @(posedge clk) begin : model_p
    int  c;
    int  per;
    bit  cap;
    cyc = cyc + 1;
    cap = 1'b0;
    per = 0;
    if (!resetn) begin
      have_prev = 1'b0;
      last_rst  = cyc;
      for (int k = 0; k < 2; k++) begin
        m_o[k] = 0; m_v[k] = 1'b0; m_ovf[k] = 1'b0; m_drop[k] = 1'b0;
      end
    end else begin
      c = cyc - LAT;
      if (c >= 0 && c < 4096 && rise_at[c] && last_rst <= c) begin
        if (have_prev) begin
          cap = 1'b1;
          per = c - prev_c;
        end
        have_prev = 1'b1;
        prev_c    = c;
      end
      for (int k = 0; k < 2; k++) begin
        if (cap) begin
          if (!m_v[k] || ready) begin
            m_o[k]   = (per >= m_max[k]) ? m_max[k] : per;
            m_ovf[k] = (per >= m_max[k]);
            m_v[k]   = 1'b1;
          end else begin
            m_drop[k] = 1'b1;
          end
        end else if (m_v[k] && ready) begin
          m_v[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("valid24",   int'(v24),    int'(m_v[0]));
    chk("o24",       int'(o24),    m_o[0]);
    chk("ovf24",     int'(ovf24),  int'(m_ovf[0]));
    chk("dropped24", int'(drop24), int'(m_drop[0]));
    chk("valid8",    int'(v8),     int'(m_v[1]));
    chk("o8",        int'(o8),     m_o[1]);
    chk("ovf8",      int'(ovf8),   int'(m_ovf[1]));
    chk("dropped8",  int'(drop8),  int'(m_drop[1]));
    if (v24 && first_valid < 0) first_valid = cyc;
    if (v24 && ready) q24.push_back(int'(o24));
    if (v8 && ready) begin
      q8.push_back(int'(o8));
      qovf8.push_back(int'(ovf8));
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rise();
    if (!pin && cyc < 4096) rise_at[cyc] = 1'b1;
    pin = 1'b1;
  endtask

  task automatic pulse(int per, int hi);
    rise();
    step(hi);
    pin = 1'b0;
    step(per - hi);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  int e1;
  int exp3[4] = '{7, 13, 7, 13};

  initial begin
    // Reset state
    step(3);
    chk("rst_valid", int'(v24), 0);
    chk("rst_o", int'(o24), 0);
    chk("rst_dropped", int'(drop24), 0);
    resetn = 1'b1;
    step(3);

    // Period 10 square wave, READY high
    ready = 1'b1;
    first_valid = -1;
    q24.delete();
    e1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) e1 = cyc;
      pulse(10, 5);
    end
    step(6);
    chk("t1_first_valid_cycle", first_valid, e1 + SYNC + 2);
    chk("t1_result_count", q24.size(), 5);
    for (int i = 0; i < q24.size(); i++) chk("t1_o", q24[i], 10);

    // Period 10 stream with READY low: hold, then drop
    do_reset();
    ready = 1'b0;
    repeat (3) pulse(10, 5);
    step(2);
    chk("t2_o_held", int'(o24), 10);
    chk("t2_valid_held", int'(v24), 1);
    chk("t2_dropped", int'(drop24), 1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("t2_valid_after_accept", int'(v24), 0);
    chk("t2_o_retained", int'(o24), 10);
    step(2);

    // Reset mid-way through a 50-cycle period
    ready = 1'b1;
    rise();
    step(5);
    pin = 1'b0;
    step(20);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    chk("t5_o_zero", int'(o24), 0);
    chk("t5_valid_zero", int'(v24), 0);
    chk("t5_ovf_zero", int'(ovf24), 0);
    chk("t5_dropped_zero", int'(drop24), 0);
    step(24);
    q24.delete();
    pulse(50, 5);
    pulse(50, 5);
    step(6);
    chk("t5_result_count", q24.size(), 1);
    chk("t5_o", (q24.size() > 0) ? q24[0] : -1, 50);

    // Alternating 7 / 13 periods
    do_reset();
    ready = 1'b1;
    q24.delete();
    pulse(7, 3);
    pulse(13, 3);
    pulse(7, 3);
    pulse(13, 3);
    rise();
    step(3);
    pin = 1'b0;
    step(6);
    chk("t3_result_count", q24.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_o", (i < q24.size()) ? q24[i] : -1, exp3[i]);

    // Saturation on the 8-bit instance
    do_reset();
    q24.delete();
    q8.delete();
    qovf8.delete();
    pulse(300, 5);
    pulse(20, 5);
    rise();
    step(5);
    pin = 1'b0;
    step(6);
    chk("t4_count8", q8.size(), 2);
    chk("t4_o8_sat", (q8.size() > 0) ? q8[0] : -1, 255);
    chk("t4_ovf8_sat", (qovf8.size() > 0) ? qovf8[0] : -1, 1);
    chk("t4_o8_next", (q8.size() > 1) ? q8[1] : -1, 20);
    chk("t4_ovf8_next", (qovf8.size() > 1) ? qovf8[1] : -1, 0);
    chk("t4_o24_wide", (q24.size() > 0) ? q24[0] : -1, 300);

    // Capture coinciding with accept
    do_reset();
    ready = 1'b0;
    pulse(8, 3);
    pulse(12, 3);
    rise();
    step(3);
    chk("t6_o_before", int'(o24), 8);
    chk("t6_valid_before", int'(v24), 1);
    ready = 1'b1;
    step(1);
    chk("t6_valid_stays", int'(v24), 1);
    chk("t6_o_new", int'(o24), 12);
    chk("t6_dropped_clear", int'(drop24), 0);
    step(1);
    chk("t6_valid_after", int'(v24), 0);
    pin = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
